ysyx_25060170_ifu_fetch: RTL

Instruction fetch stage directly upstream of the decode stage. It owns the architectural fetch PC and issues in-order 32-bit fetches over a valid/ready request channel to instruction memory. Returned words are buffered with their PC in a 2-entry queue that drives the decode stage. It honours the decode-stage load-use stall and flushes the whole fetch stream on a redirect from execute.

---
 rtl/ysyx_25060170_ifu_fetch.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25060170_ifu_fetch.sv
// ysyx_25060170_ifu_fetch
// Instruction fetch stage. Owns the fetch PC, issues in-order word fetches on
// a valid/ready channel, tags each accepted request with its PC in a small
// in-flight queue, and buffers returned words with their PC in a 2-entry
// output queue that feeds the decode stage. A redirect from execute flushes
// both queues and turns every outstanding response into a word to discard.
module ysyx_25060170_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    // Architectural fetch PC.
    logic [31:0] pc_r;

    // Output queue: circular, two entries, head pointer plus occupancy.
    logic [31:0] q_pc_r   [2];
    logic [31:0] q_inst_r [2];
    logic        q_head_r;
    logic [1:0]  q_count_r;

    // In-flight PC queue: PCs of accepted requests whose words are still wanted.
    logic [31:0] f_pc_r [2];
    logic        f_head_r;
    logic        f_tail_r;

    // Outstanding requests at the memory, and how many of them are stale.
    logic [1:0]  osd_r;
    logic [1:0]  drop_r;

    logic        if_valid_s;
    logic        pop_s;
    logic [2:0]  credit_use_s;
    logic        req_valid_s;
    logic        req_fire_s;
    logic        rsp_keep_s;
    logic        rsp_drop_s;
    logic        q_tail_s;
    logic [1:0]  osd_next_s;
    logic [1:0]  osd_norm_s;
    logic [1:0]  q_count_next_s;
    logic [31:0] redirect_target_s;

    // Handshake decode: handoff, credit check, request accept, response routing.
    always_comb begin
        if_valid_s        = (q_count_r != 2'd0);
        pop_s             = if_valid_s & id_ready & ~id_stall & ~redirect_valid;
        // Slots already promised (outstanding + buffered) after this cycle's handoff.
        credit_use_s      = {1'b0, osd_r} + {1'b0, q_count_r} - {2'b00, pop_s};
        req_valid_s       = ~rst & ~redirect_valid & (credit_use_s < 3'd2);
        req_fire_s        = req_valid_s & imem_req_ready;
        rsp_keep_s        = imem_rsp_valid & (drop_r == 2'd0);
        rsp_drop_s        = imem_rsp_valid & (drop_r != 2'd0);
        // With two entries the tail is head when empty or full, the other slot otherwise.
        q_tail_s          = q_head_r ^ q_count_r[0];
        redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
    end

    // Next-value arithmetic for the outstanding count and queue occupancy.
    always_comb begin
        osd_next_s     = osd_r;
        osd_norm_s     = osd_r;
        q_count_next_s = q_count_r;

        // A response in the redirect cycle still retires one outstanding request.
        if (imem_rsp_valid) begin
            osd_next_s = osd_r - 2'd1;
        end else begin
            osd_next_s = osd_r;
        end

        case ({req_fire_s, imem_rsp_valid})
            2'b10:   osd_norm_s = osd_r + 2'd1;
            2'b01:   osd_norm_s = osd_r - 2'd1;
            default: osd_norm_s = osd_r;
        endcase

        case ({rsp_keep_s, pop_s})
            2'b10:   q_count_next_s = q_count_r + 2'd1;
            2'b01:   q_count_next_s = q_count_r - 2'd1;
            default: q_count_next_s = q_count_r;
        endcase
    end

    // Output drive: request channel and queue head, zeroed when the queue is empty.
    always_comb begin
        imem_req_valid = req_valid_s;
        if_valid       = if_valid_s;
        if (rst) begin
            imem_req_addr = RESET_PC;
        end else begin
            imem_req_addr = pc_r;
        end
        if (if_valid_s) begin
            inst_o = q_inst_r[q_head_r];
            pc_o   = q_pc_r[q_head_r];
        end else begin
            inst_o = 32'd0;
            pc_o   = 32'd0;
        end
    end

    // Fetch PC: redirect target wins, otherwise advance by one word per accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= redirect_target_s;
        end else if (req_fire_s) begin
            pc_r <= pc_r + 32'd4;
        end else begin
            pc_r <= pc_r;
        end
    end

    // In-flight PC queue: push on accept, pop when a wanted word returns, clear on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_head_r <= 1'b0;
            f_tail_r <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                f_pc_r[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            f_head_r <= 1'b0;
            f_tail_r <= 1'b0;
        end else begin
            if (req_fire_s) begin
                f_pc_r[f_tail_r] <= pc_r;
                f_tail_r         <= ~f_tail_r;
            end
            if (rsp_keep_s) begin
                f_head_r <= ~f_head_r;
            end
        end
    end

    // Output queue: enqueue wanted words with their PC, dequeue on handoff, flush on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_head_r  <= 1'b0;
            q_count_r <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_pc_r[i]   <= 32'd0;
                q_inst_r[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            q_head_r  <= 1'b0;
            q_count_r <= 2'd0;
        end else begin
            // When full with a simultaneous pop, the tail slot is the head being vacated.
            if (rsp_keep_s) begin
                q_pc_r[q_tail_s]   <= f_pc_r[f_head_r];
                q_inst_r[q_tail_s] <= imem_rsp_data;
            end
            if (pop_s) begin
                q_head_r <= ~q_head_r;
            end
            q_count_r <= q_count_next_s;
        end
    end

    // Outstanding and drop counters: on redirect every remaining outstanding word is stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            osd_r  <= 2'd0;
            drop_r <= 2'd0;
        end else if (redirect_valid) begin
            osd_r  <= osd_next_s;
            drop_r <= osd_next_s;
        end else begin
            osd_r <= osd_norm_s;
            if (rsp_drop_s) begin
                drop_r <= drop_r - 2'd1;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

endmodule
